// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: write-extension mode
// encodings used by both the decoder and the writeback path.
package regfile_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        WM_WORD = 3'b000,
        WM_LB   = 3'b001,
        WM_LH   = 3'b010,
        WM_LBU  = 3'b011,
        WM_LHU  = 3'b100
    } wr_mode_e;

endpackage

// File: rtl/regfile_mp_load_ext.sv
// Combinational sub-word load extension: sign/zero extends the low byte or
// half of the raw writeback data; unknown mode codes pass the word through.
module load_ext
    import regfile_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]   data,
    input  logic [MODE_W-1:0] mode,
    output logic [XLEN-1:0]   ext
);

    always_comb begin
        ext = data;
        case (mode)
            WM_LB:   ext = {{(XLEN-8){data[7]}}, data[7:0]};
            WM_LH:   ext = {{(XLEN-16){data[15]}}, data[15:0]};
            WM_LBU:  ext = {{(XLEN-8){1'b0}}, data[7:0]};
            WM_LHU:  ext = {{(XLEN-16){1'b0}}, data[15:0]};
            default: ext = data;
        endcase
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with load extension, same-cycle
// write-to-read bypass, pending-load scoreboard and write-collision flag.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN   = 32,
    parameter  int NREG   = 32,
    parameter  int NRD    = 3,
    parameter  int NWR    = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NRD*AW-1:0]      rd_addr,
    output logic [NRD*XLEN-1:0]    rd_data,
    output logic [NRD-1:0]         rd_busy,
    input  logic [NWR-1:0]         wr_en,
    input  logic [NWR*AW-1:0]      wr_addr,
    input  logic [NWR*XLEN-1:0]    wr_data,
    input  logic [NWR*MODE_W-1:0]  wr_mode,
    input  logic                   busy_set_en,
    input  logic [AW-1:0]          busy_set_addr,
    input  logic [AW-1:0]          dbg_sel,
    output logic [XLEN-1:0]        dbg_data,
    output logic                   wr_conflict
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [XLEN-1:0] ext_data [NWR];
    logic [NREG-1:0] reg_we;
    logic [XLEN-1:0] reg_wd [NREG];
    logic            conflict_nxt;

    for (genvar w = 0; w < NWR; w++) begin : g_ext
        load_ext #(.XLEN(XLEN)) u_load_ext (
            .data (wr_data[w*XLEN +: XLEN]),
            .mode (wr_mode[w*MODE_W +: MODE_W]),
            .ext  (ext_data[w])
        );
    end

    // Ascending port scan: a later (higher-index) port overwrites an earlier one.
    always_comb begin
        reg_we = '0;
        for (int r = 0; r < NREG; r++) reg_wd[r] = '0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && wr_addr[w*AW +: AW] != '0) begin
                reg_we[wr_addr[w*AW +: AW]] = 1'b1;
                reg_wd[wr_addr[w*AW +: AW]] = ext_data[w];
            end
        end
    end

    always_comb begin
        conflict_nxt = 1'b0;
        for (int i = 0; i < NWR; i++) begin
            for (int j = i + 1; j < NWR; j++) begin
                if (wr_en[i] && wr_en[j] && wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW]
                    && wr_addr[i*AW +: AW] != '0)
                    conflict_nxt = 1'b1;
            end
        end
    end

    // Clear on writeback first, then set, so a newly issued load keeps the bit.
    always_comb begin
        busy_nxt = busy & ~reg_we;
        if (busy_set_en && busy_set_addr != '0)
            busy_nxt[busy_set_addr] = 1'b1;
    end

    // Register 0 is cleared here and never written, so it reads 0 everywhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
            busy        <= '0;
            wr_conflict <= 1'b0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (reg_we[r]) regs[r] <= reg_wd[r];
            end
            busy        <= busy_nxt;
            wr_conflict <= conflict_nxt;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            hit;
        logic [XLEN-1:0] byp_data;
        logic            byp_ok;
        logic            set_here;

        assign addr = rd_addr[p*AW +: AW];

        always_comb begin
            hit      = 1'b0;
            byp_data = '0;
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w] && wr_addr[w*AW +: AW] == addr) begin
                    hit      = 1'b1;
                    byp_data = ext_data[w];
                end
            end
        end

        // Bypass is suppressed in reset so outputs read 0 while rst is held.
        assign byp_ok   = (BYPASS != 0) && hit && (addr != '0) && !rst;
        assign set_here = busy_set_en && (busy_set_addr == addr);

        assign rd_data[p*XLEN +: XLEN] = byp_ok ? byp_data : regs[addr];
        assign rd_busy[p]              = busy[addr] & ~(byp_ok & ~set_here);
    end

    assign dbg_data = regs[dbg_sel];

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized
// traffic against an array-based reference model, for BYPASS=1 and BYPASS=0.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 3;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*XLEN-1:0]   rd_data, rd_data_nb;
    logic [NRD-1:0]        rd_busy, rd_busy_nb;
    logic [NWR-1:0]        wr_en;
    logic [NWR*AW-1:0]     wr_addr;
    logic [NWR*XLEN-1:0]   wr_data;
    logic [NWR*3-1:0]      wr_mode;
    logic                  busy_set_en;
    logic [AW-1:0]         busy_set_addr;
    logic [AW-1:0]         dbg_sel;
    logic [XLEN-1:0]       dbg_data, dbg_data_nb;
    logic                  wr_conflict, wr_conflict_nb;

    int errors = 0;
    int checks = 0;

    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];
    bit              m_conf;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mode(wr_mode),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data), .wr_conflict(wr_conflict)
    );

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mode(wr_mode),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data_nb), .wr_conflict(wr_conflict_nb)
    );

    // ---------------- reference model ----------------
    function automatic logic [XLEN-1:0] ext_model(logic [XLEN-1:0] d, logic [2:0] m);
        int v;
        case (m)
            3'd1: begin v = int'(d & 32'hFF);   if (v >= 128)   v -= 256;   return v; end
            3'd2: begin v = int'(d & 32'hFFFF); if (v >= 32768) v -= 65536; return v; end
            3'd3: return d & 32'hFF;
            3'd4: return d & 32'hFFFF;
            default: return d;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(bit byp, logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        if (rst || a == 0) return '0;
        v = m_regs[a];
        if (byp)
            for (int w = 0; w < NWR; w++)
                if (wr_en[w] && wr_addr[w*AW +: AW] == a)
                    v = ext_model(wr_data[w*XLEN +: XLEN], wr_mode[w*3 +: 3]);
        return v;
    endfunction

    function automatic bit exp_busy(bit byp, logic [AW-1:0] a);
        bit hit = 0;
        if (rst || a == 0) return 1'b0;
        for (int w = 0; w < NWR; w++)
            if (wr_en[w] && wr_addr[w*AW +: AW] == a) hit = 1;
        if (byp && hit && !(busy_set_en && busy_set_addr == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [NRD*XLEN-1:0] exp_rd_vec(bit byp);
        logic [NRD*XLEN-1:0] v;
        for (int p = 0; p < NRD; p++) v[p*XLEN +: XLEN] = exp_rd(byp, rd_addr[p*AW +: AW]);
        return v;
    endfunction

    function automatic logic [NRD-1:0] exp_busy_vec(bit byp);
        logic [NRD-1:0] v;
        for (int p = 0; p < NRD; p++) v[p] = exp_busy(byp, rd_addr[p*AW +: AW]);
        return v;
    endfunction

    task automatic m_reset();
        for (int a = 0; a < NREG; a++) begin m_regs[a] = '0; m_busy[a] = 0; end
        m_conf = 0;
    endtask

    // Advance one clock edge, updating the model from the inputs held across it.
    task automatic step();
        logic [XLEN-1:0] nr [NREG];
        bit              nbz [NREG];
        int              cnt [NREG];
        bit              nc;
        nr = m_regs; nbz = m_busy; nc = 0;
        for (int a = 0; a < NREG; a++) cnt[a] = 0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w]) begin
                int a;
                a = int'(wr_addr[w*AW +: AW]);
                cnt[a]++;
                if (a != 0) begin
                    nr[a]  = ext_model(wr_data[w*XLEN +: XLEN], wr_mode[w*3 +: 3]);
                    nbz[a] = 0;
                end
            end
        end
        if (busy_set_en && busy_set_addr != 0) nbz[busy_set_addr] = 1;
        for (int a = 1; a < NREG; a++) if (cnt[a] > 1) nc = 1;
        @(posedge clk);
        if (!rst) begin m_regs = nr; m_busy = nbz; m_conf = nc; end
        #1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0; wr_mode = '0;
        busy_set_en = 1'b0; busy_set_addr = '0;
    endtask

    task automatic set_wr(input int w, input bit en, input int a, input logic [XLEN-1:0] d, input int m);
        wr_en[w]              = en;
        wr_addr[w*AW +: AW]   = AW'(a);
        wr_data[w*XLEN +: XLEN] = d;
        wr_mode[w*3 +: 3]     = 3'(m);
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++;
        if (rd_data !== '0 || rd_busy !== '0 || wr_conflict !== 1'b0 || dbg_data !== '0) begin
            errors++;
            $display("FAIL reset_init: rd_data=%h busy=%b conf=%b dbg=%h, required all 0",
                     rd_data, rd_busy, wr_conflict, dbg_data);
        end
        rst = 1'b0;
        idle(); set_wr(0, 1, 5, 32'h1234, 0); busy_set_en = 1; busy_set_addr = 6;
        step(); idle();
        set_rd(0, 5); set_rd(1, 6); #1;
        checks++;
        if (rd_data[0 +: XLEN] !== 32'h1234) begin
            errors++; $display("FAIL reset_pre_write: got %h, required %h", rd_data[0 +: XLEN], 32'h1234);
        end
        checks++;
        if (rd_busy[1] !== 1'b1) begin
            errors++; $display("FAIL reset_pre_busy: got %b, required 1", rd_busy[1]);
        end
        set_wr(0, 1, 5, 32'hAAAA5555, 0); busy_set_en = 1; busy_set_addr = 7; set_rd(2, 5);
        rst = 1'b1; m_reset(); #1;
        checks++;
        if (rd_data !== '0 || rd_busy !== '0 || rd_data_nb !== '0 || rd_busy_nb !== '0) begin
            errors++;
            $display("FAIL reset_async: rd_data=%h busy=%b nb_data=%h nb_busy=%b, required all 0",
                     rd_data, rd_busy, rd_data_nb, rd_busy_nb);
        end
        step();
        rst = 1'b0; idle(); set_rd(0, 5); set_rd(1, 6); set_rd(2, 7); #1;
        checks++;
        if (rd_data !== '0 || rd_busy !== '0 || wr_conflict !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard: rd_data=%h busy=%b conf=%b, required all 0", rd_data, rd_busy, wr_conflict);
        end
        set_wr(0, 1, 0, 32'hFFFFFFFF, 0); set_wr(1, 1, 0, 32'hFFFFFFFF, 0);
        busy_set_en = 1; busy_set_addr = 0; set_rd(0, 0); #1;
        checks++;
        if (rd_data[0 +: XLEN] !== '0) begin
            errors++; $display("FAIL r0_bypass: got %h, required 0", rd_data[0 +: XLEN]);
        end
        step(); idle(); dbg_sel = 0; #1;
        checks++;
        if (rd_data[0 +: XLEN] !== '0 || rd_busy[0] !== 1'b0 || wr_conflict !== 1'b0 || dbg_data !== '0) begin
            errors++;
            $display("FAIL r0_write: data=%h busy=%b conf=%b dbg=%h, required 0/0/0/0",
                     rd_data[0 +: XLEN], rd_busy[0], wr_conflict, dbg_data);
        end
    endtask

    task automatic test_extension();
        logic [XLEN-1:0] tbl [8];
        tbl = '{32'h00008F80, 32'hFFFFFF80, 32'hFFFF8F80, 32'h00000080,
                32'h00008F80, 32'h00008F80, 32'h00008F80, 32'h00008F80};
        for (int m = 0; m < 8; m++) begin
            idle(); set_wr(1, 1, 3, 32'h00008F80, m);
            step(); idle(); set_rd(1, 3); #1;
            checks++;
            if (rd_data[XLEN +: XLEN] !== tbl[m] || rd_data_nb[XLEN +: XLEN] !== tbl[m]) begin
                errors++;
                $display("FAIL ext_mode%0d: got %h/%h, required %h", m,
                         rd_data[XLEN +: XLEN], rd_data_nb[XLEN +: XLEN], tbl[m]);
            end
        end
    endtask

    task automatic test_bypass();
        idle(); set_wr(0, 1, 7, 32'h00001111, 0); step();
        idle(); set_wr(0, 1, 7, 32'hDEADBEEF, 0); set_rd(0, 7); dbg_sel = 7; #1;
        checks++;
        if (rd_data[0 +: XLEN] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL bypass_on: got %h, required %h", rd_data[0 +: XLEN], 32'hDEADBEEF);
        end
        checks++;
        if (rd_data_nb[0 +: XLEN] !== 32'h00001111 || dbg_data !== 32'h00001111) begin
            errors++;
            $display("FAIL bypass_off_old: nb=%h dbg=%h, required %h", rd_data_nb[0 +: XLEN], dbg_data, 32'h1111);
        end
        step(); idle(); #1;
        checks++;
        if (rd_data_nb[0 +: XLEN] !== 32'hDEADBEEF || dbg_data_nb !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_off_new: nb=%h dbg=%h, required %h", rd_data_nb[0 +: XLEN], dbg_data_nb, 32'hDEADBEEF);
        end
    endtask

    task automatic test_collision();
        idle(); set_wr(0, 1, 9, 32'h11, 0); set_wr(1, 1, 9, 32'h22, 0); set_rd(1, 9); #1;
        checks++;
        if (rd_data[XLEN +: XLEN] !== 32'h22 || wr_conflict !== 1'b0) begin
            errors++;
            $display("FAIL coll_same: data=%h conf=%b, required 22/0", rd_data[XLEN +: XLEN], wr_conflict);
        end
        step(); idle(); #1;
        checks++;
        if (rd_data[XLEN +: XLEN] !== 32'h22 || rd_data_nb[XLEN +: XLEN] !== 32'h22 ||
            wr_conflict !== 1'b1 || wr_conflict_nb !== 1'b1) begin
            errors++;
            $display("FAIL coll_after: data=%h/%h conf=%b/%b, required 22/22/1/1",
                     rd_data[XLEN +: XLEN], rd_data_nb[XLEN +: XLEN], wr_conflict, wr_conflict_nb);
        end
        step(); #1;
        checks++;
        if (wr_conflict !== 1'b0 || wr_conflict_nb !== 1'b0) begin
            errors++; $display("FAIL coll_clear: conf=%b/%b, required 0/0", wr_conflict, wr_conflict_nb);
        end
    endtask

    task automatic test_scoreboard();
        idle(); busy_set_en = 1; busy_set_addr = 4; set_rd(0, 4); #1;
        checks++;
        if (rd_busy[0] !== 1'b0) begin
            errors++; $display("FAIL sb_set_early: got %b, required 0", rd_busy[0]);
        end
        step(); idle(); #1;
        checks++;
        if (rd_busy[0] !== 1'b1 || rd_busy_nb[0] !== 1'b1) begin
            errors++; $display("FAIL sb_set: got %b/%b, required 1/1", rd_busy[0], rd_busy_nb[0]);
        end
        set_wr(0, 1, 4, 32'hCAFE, 0); #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || rd_busy_nb[0] !== 1'b1) begin
            errors++; $display("FAIL sb_wb_same: got %b/%b, required 0/1", rd_busy[0], rd_busy_nb[0]);
        end
        step(); idle(); #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || rd_busy_nb[0] !== 1'b0) begin
            errors++; $display("FAIL sb_cleared: got %b/%b, required 0/0", rd_busy[0], rd_busy_nb[0]);
        end
        set_wr(1, 1, 4, 32'hBEEF, 0); busy_set_en = 1; busy_set_addr = 4;
        step(); #1;
        checks++;
        if (rd_busy[0] !== 1'b1 || rd_busy_nb[0] !== 1'b1) begin
            errors++; $display("FAIL sb_set_wins: got %b/%b, required 1/1", rd_busy[0], rd_busy_nb[0]);
        end
        step(); idle(); #1;
        checks++;
        if (rd_busy[0] !== 1'b1 || rd_data[0 +: XLEN] !== 32'hBEEF) begin
            errors++;
            $display("FAIL sb_still_busy: busy=%b data=%h, required 1/%h", rd_busy[0], rd_data[0 +: XLEN], 32'hBEEF);
        end
    endtask

    task automatic test_random();
        int a0, a1, a2;
        for (int c = 0; c < 31; c++) begin
            idle();
            for (int w = 0; w < NWR; w++)
                set_wr(w, $urandom_range(0, 3) != 0,
                       ($urandom_range(0, 3) == 0) ? $urandom_range(8, 10) : $urandom_range(0, NREG - 1),
                       $urandom, $urandom_range(0, 7));
            busy_set_en   = $urandom_range(0, 1);
            busy_set_addr = AW'($urandom_range(0, NREG - 1));
            for (int p = 0; p < NRD; p++) set_rd(p, $urandom_range(0, NREG - 1));
            dbg_sel = AW'($urandom_range(0, NREG - 1));
            #1;
            checks++;
            if (rd_data !== exp_rd_vec(1) || rd_data_nb !== exp_rd_vec(0)) begin
                errors++;
                $display("FAIL rand_data c%0d: got %h / %h, required %h / %h", c,
                         rd_data, rd_data_nb, exp_rd_vec(1), exp_rd_vec(0));
            end
            checks++;
            if (rd_busy !== exp_busy_vec(1) || rd_busy_nb !== exp_busy_vec(0)) begin
                errors++;
                $display("FAIL rand_busy c%0d: got %b / %b, required %b / %b", c,
                         rd_busy, rd_busy_nb, exp_busy_vec(1), exp_busy_vec(0));
            end
            checks++;
            if (dbg_data !== m_regs[dbg_sel] || dbg_data_nb !== m_regs[dbg_sel] ||
                wr_conflict !== m_conf || wr_conflict_nb !== m_conf) begin
                errors++;
                $display("FAIL rand_dbg_conf c%0d: dbg=%h/%h conf=%b/%b, required %h conf=%b", c,
                         dbg_data, dbg_data_nb, wr_conflict, wr_conflict_nb, m_regs[dbg_sel], m_conf);
            end
            step();
        end
        idle();
        a0 = $urandom_range(1, 7); a1 = $urandom_range(8, 15); a2 = $urandom_range(16, 23);
        set_rd(0, a0); set_rd(1, a1); set_rd(2, a2);
        dbg_sel = AW'($urandom_range(24, 31));
        #1;
        checks++;
        if (rd_data !== exp_rd_vec(1) || rd_busy !== exp_busy_vec(1) || dbg_data !== m_regs[dbg_sel]) begin
            errors++;
            $display("FAIL multi_read: data=%h busy=%b dbg=%h, required %h %b %h",
                     rd_data, rd_busy, dbg_data, exp_rd_vec(1), exp_busy_vec(1), m_regs[dbg_sel]);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rd_addr = '0;
        dbg_sel = '0;
        m_reset();
        #12;
        test_reset();
        test_extension();
        test_bypass();
        test_collision();
        test_scoreboard();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
